// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback sources,
// forward selects, multiplier-tracker state and the register-match helper.
package hazard_pkg;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC8 = 3'd2;
    localparam logic [2:0] WB_HI  = 3'd3;
    localparam logic [2:0] WB_LO  = 3'd4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MultIdle,
        MultBusy
    } multStateT;

    // $zero is hardwired, so a write to it never creates a dependency.
    function automatic logic regHit(logic [4:0] dst, logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: per-stage observations in,
// stall/flush/forward controls and multiplier status out.
interface hazard_ctrl_if;

    logic [1:0] branchD;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic       RegWriteE;
    logic [2:0] WBSrcE;
    logic       MultStartE;
    logic       MultDoneE;
    logic [4:0] WriteRegM;
    logic       RegWriteM;
    logic [2:0] WBSrcM;
    logic [4:0] WriteRegW;
    logic       RegWriteW;

    logic       stallF;
    logic       stallD;
    logic       flushE;
    logic       forwardAD;
    logic       forwardBD;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       mult_busy;
    logic       mult_fault;

    modport master (
        output branchD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, WBSrcE,
               MultStartE, MultDoneE, WriteRegM, RegWriteM, WBSrcM,
               WriteRegW, RegWriteW,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE,
               forwardBE, mult_busy, mult_fault
    );

    modport slave (
        input  branchD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, WBSrcE,
               MultStartE, MultDoneE, WriteRegM, RegWriteM, WBSrcM,
               WriteRegW, RegWriteW,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE,
               forwardBE, mult_busy, mult_fault
    );

endinterface

// File: rtl/mult_tracker.sv
// Multiplier occupancy tracker: IDLE/BUSY FSM with a watchdog that abandons
// a multiply after MULT_TIMEOUT busy cycles and raises a sticky fault.
module mult_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic multStart,
    input  logic multDone,
    output logic busy,
    output logic fault
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MULT_TIMEOUT - 1);

    multStateT        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             faultQ, faultD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= MultIdle;
            cntQ   <= '0;
            faultQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            faultQ <= faultD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        faultD = faultQ;
        unique case (stateQ)
            MultIdle: begin
                if (multStart) begin
                    stateD = MultBusy;
                    cntD   = '0;
                end
            end
            MultBusy: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (multDone) begin
                    stateD = MultIdle;
                end else if (cntQ == LastCnt) begin
                    stateD = MultIdle;
                    faultD = 1'b1;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            default: stateD = MultIdle;
        endcase
    end

    assign busy  = (stateQ == MultBusy);
    assign fault = faultQ;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/multiplier
// stalls. Optional per-term stall counters when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  lw_stall_cnt,
    output logic [31:0]  br_stall_cnt,
    output logic [31:0]  mult_stall_cnt
`endif
);

    logic       multBusy;
    logic       multFault;
    logic       lwStall;
    logic       brStall;
    logic       mStall;
    logic       anyStall;
    logic       srcHitE;
    logic       srcHitM;
    logic [1:0] fwdA;
    logic [1:0] fwdB;

    mult_tracker #(
        .MULT_TIMEOUT(MULT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mult_tracker (
        .clk      (clk),
        .rst      (rst),
        .multStart(hz.MultStartE),
        .multDone (hz.MultDoneE),
        .busy     (multBusy),
        .fault    (multFault)
    );

    // M has the newer value, so it takes priority over W.
    always_comb begin
        fwdA = FWD_RF;
        if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RsE)) begin
            fwdA = FWD_M;
        end else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RsE)) begin
            fwdA = FWD_W;
        end
    end

    always_comb begin
        fwdB = FWD_RF;
        if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RtE)) begin
            fwdB = FWD_M;
        end else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RtE)) begin
            fwdB = FWD_W;
        end
    end

    assign srcHitE = regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD);
    assign srcHitM = regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD);

    // Branches resolve in D, so an ALU result still in E or a load in M is too late.
    assign lwStall  = (hz.WBSrcE == WB_MEM) && srcHitE;
    assign brStall  = (hz.branchD != 2'b00) &&
                      ((hz.RegWriteE && srcHitE) || ((hz.WBSrcM == WB_MEM) && srcHitM));
    assign mStall   = multBusy && !hz.MultDoneE;
    assign anyStall = !rst && (lwStall || brStall || mStall);

    assign hz.stallF     = anyStall;
    assign hz.stallD     = anyStall;
    assign hz.flushE     = anyStall;
    assign hz.forwardAD  = !rst && hz.RegWriteM && regHit(hz.WriteRegM, hz.RsD);
    assign hz.forwardBD  = !rst && hz.RegWriteM && regHit(hz.WriteRegM, hz.RtD);
    assign hz.forwardAE  = rst ? FWD_RF : fwdA;
    assign hz.forwardBE  = rst ? FWD_RF : fwdB;
    assign hz.mult_busy  = multBusy;
    assign hz.mult_fault = multFault;

`ifdef HAZARD_PERF_EN
    logic [31:0] lwCntQ, brCntQ, mCntQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lwCntQ <= '0;
            brCntQ <= '0;
            mCntQ  <= '0;
        end else begin
            if (lwStall && (lwCntQ != '1)) lwCntQ <= lwCntQ + 32'd1;
            if (brStall && (brCntQ != '1)) brCntQ <= brCntQ + 32'd1;
            if (mStall && (mCntQ != '1))   mCntQ  <= mCntQ + 32'd1;
        end
    end

    assign lw_stall_cnt   = lwCntQ;
    assign br_stall_cnt   = brCntQ;
    assign mult_stall_cnt = mCntQ;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default-timeout instance and a timeout-8 instance
// share stimulus and are checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    bit   running = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   stallCnt;

    always #5 clk = ~clk;

    hazard_ctrl_if hz ();
    hazard_ctrl_if hz8 ();

    assign hz8.branchD    = hz.branchD;
    assign hz8.RsD        = hz.RsD;
    assign hz8.RtD        = hz.RtD;
    assign hz8.RsE        = hz.RsE;
    assign hz8.RtE        = hz.RtE;
    assign hz8.WriteRegE  = hz.WriteRegE;
    assign hz8.RegWriteE  = hz.RegWriteE;
    assign hz8.WBSrcE     = hz.WBSrcE;
    assign hz8.MultStartE = hz.MultStartE;
    assign hz8.MultDoneE  = hz.MultDoneE;
    assign hz8.WriteRegM  = hz.WriteRegM;
    assign hz8.RegWriteM  = hz.RegWriteM;
    assign hz8.WBSrcM     = hz.WBSrcM;
    assign hz8.WriteRegW  = hz.WriteRegW;
    assign hz8.RegWriteW  = hz.RegWriteW;

`ifdef HAZARD_PERF_EN
    logic [31:0] lwCnt, brCnt, mCnt, lwCnt8, brCnt8, mCnt8;
`endif

    hazard_ctrl #(.MULT_TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
`ifdef HAZARD_PERF_EN
        ,
        .lw_stall_cnt  (lwCnt),
        .br_stall_cnt  (brCnt),
        .mult_stall_cnt(mCnt)
`endif
    );

    hazard_ctrl #(.MULT_TIMEOUT(8), .CNT_W(4)) dut8 (
        .clk(clk),
        .rst(rst),
        .hz (hz8)
`ifdef HAZARD_PERF_EN
        ,
        .lw_stall_cnt  (lwCnt8),
        .br_stall_cnt  (brCnt8),
        .mult_stall_cnt(mCnt8)
`endif
    );

    // ---------------- behavioural model ----------------
    int unsigned timeoutOf[2] = '{64, 8};
    bit          mBusy[2];
    int unsigned mSpent[2];
    bit          mFault[2];
    int unsigned lwCntM, brCntM, mCntM;

    function automatic bit dep(logic [4:0] dst, logic [4:0] src);
        return dst != 0 && dst == src;
    endfunction

    function automatic bit lwExp();
        return hz.WBSrcE == WB_MEM && (dep(hz.WriteRegE, hz.RsD) || dep(hz.WriteRegE, hz.RtD));
    endfunction

    function automatic bit brExp();
        bit eHit, mHit;
        eHit = hz.RegWriteE && (dep(hz.WriteRegE, hz.RsD) || dep(hz.WriteRegE, hz.RtD));
        mHit = hz.WBSrcM == WB_MEM && (dep(hz.WriteRegM, hz.RsD) || dep(hz.WriteRegM, hz.RtD));
        return hz.branchD != 0 && (eHit || mHit);
    endfunction

    function automatic logic [1:0] fwdExp(logic [4:0] src);
        if (hz.RegWriteM && dep(hz.WriteRegM, src)) return FWD_M;
        if (hz.RegWriteW && dep(hz.WriteRegW, src)) return FWD_W;
        return FWD_RF;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mBusy[i]  <= 1'b0;
                mSpent[i] <= 0;
                mFault[i] <= 1'b0;
            end
            lwCntM <= 0;
            brCntM <= 0;
            mCntM  <= 0;
        end else begin
            lwCntM <= lwCntM + (lwExp() ? 1 : 0);
            brCntM <= brCntM + (brExp() ? 1 : 0);
            mCntM  <= mCntM + ((mBusy[0] && !hz.MultDoneE) ? 1 : 0);
            for (int i = 0; i < 2; i++) begin
                if (!mBusy[i]) begin
                    if (hz.MultStartE) begin
                        mBusy[i]  <= 1'b1;
                        mSpent[i] <= 0;
                    end
                end else if (hz.MultDoneE) begin
                    mBusy[i] <= 1'b0;
                end else if (mSpent[i] + 1 == timeoutOf[i]) begin
                    mBusy[i]  <= 1'b0;
                    mFault[i] <= 1'b1;
                end else begin
                    mSpent[i] <= mSpent[i] + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    task automatic checkInst(int i, logic sF, logic sD, logic fE, logic aD, logic bD,
                             logic [1:0] aE, logic [1:0] bE, logic busy, logic fault);
        bit st;
        st = !rst && (lwExp() || brExp() || (mBusy[i] && !hz.MultDoneE));
        check($sformatf("i%0d stallF", i), sF, st);
        check($sformatf("i%0d stallD", i), sD, st);
        check($sformatf("i%0d flushE", i), fE, st);
        check($sformatf("i%0d forwardAD", i), aD, !rst && hz.RegWriteM && dep(hz.WriteRegM, hz.RsD));
        check($sformatf("i%0d forwardBD", i), bD, !rst && hz.RegWriteM && dep(hz.WriteRegM, hz.RtD));
        check($sformatf("i%0d forwardAE", i), aE, rst ? 2'b00 : fwdExp(hz.RsE));
        check($sformatf("i%0d forwardBE", i), bE, rst ? 2'b00 : fwdExp(hz.RtE));
        check($sformatf("i%0d mult_busy", i), busy, !rst && mBusy[i]);
        check($sformatf("i%0d mult_fault", i), fault, !rst && mFault[i]);
    endtask

    always @(negedge clk) begin
        if (running) begin
            checkInst(0, hz.stallF, hz.stallD, hz.flushE, hz.forwardAD, hz.forwardBD,
                      hz.forwardAE, hz.forwardBE, hz.mult_busy, hz.mult_fault);
            checkInst(1, hz8.stallF, hz8.stallD, hz8.flushE, hz8.forwardAD, hz8.forwardBD,
                      hz8.forwardAE, hz8.forwardBE, hz8.mult_busy, hz8.mult_fault);
`ifdef HAZARD_PERF_EN
            check("lw_stall_cnt", lwCnt, lwCntM);
            check("br_stall_cnt", brCnt, brCntM);
            check("mult_stall_cnt", mCnt, mCntM);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearIn();
        hz.branchD = 0; hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.RegWriteE = 0; hz.WBSrcE = WB_ALU;
        hz.MultStartE = 0; hz.MultDoneE = 0;
        hz.WriteRegM = 0; hz.RegWriteM = 0; hz.WBSrcM = WB_ALU;
        hz.WriteRegW = 0; hz.RegWriteW = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseRst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clearIn();
        running = 1'b1;
        // Hazard present while in reset: outputs must stay low.
        hz.WBSrcE = WB_MEM; hz.WriteRegE = 5; hz.RtD = 5;
        repeat (2) @(posedge clk);
        #2;
        check("rst_gates_stall", hz.stallF, 0);
        check("rst_busy", hz.mult_busy, 0);
        rst = 1'b0;
        #1;
        check("lw_stallF", hz.stallF, 1);
        check("lw_stallD", hz.stallD, 1);
        check("lw_flushE", hz.flushE, 1);
        cyc();
        hz.WriteRegE = 0; hz.RtD = 0; hz.RsD = 0;
        #1 check("lw_r0_no_stall", hz.stallF, 0);

        // Forwarding priority M over W, then W alone, then $zero.
        cyc();
        clearIn();
        hz.RegWriteM = 1; hz.WriteRegM = 8; hz.RegWriteW = 1; hz.WriteRegW = 8;
        hz.RsE = 8; hz.RtE = 9;
        #1;
        check("fwdAE_M", hz.forwardAE, 2'b10);
        check("fwdBE_none", hz.forwardBE, 2'b00);
        cyc();
        hz.RegWriteM = 0;
        #1 check("fwdAE_W", hz.forwardAE, 2'b01);
        cyc();
        hz.RegWriteM = 1; hz.WriteRegM = 0; hz.RegWriteW = 0; hz.RsE = 0;
        #1 check("fwdAE_r0", hz.forwardAE, 2'b00);

        // Branch stalls on ALU result in E, then forwards from M.
        cyc();
        clearIn();
        hz.branchD = 2'b01; hz.RegWriteE = 1; hz.WriteRegE = 3; hz.RsD = 3;
        #1 check("br_stall_E", hz.stallF, 1);
        cyc();
        hz.RegWriteE = 0; hz.WriteRegE = 0;
        hz.WriteRegM = 3; hz.RegWriteM = 1; hz.WBSrcM = WB_ALU;
        #1;
        check("br_no_stall_M", hz.stallF, 0);
        check("br_forwardAD", hz.forwardAD, 1);
        cyc();
        hz.WBSrcM = WB_MEM;
        #1 check("br_stall_load_M", hz.stallD, 1);
        cyc();
        clearIn();

        // Done on the watchdog's last cycle wins (timeout-8 instance).
        pulseRst();
        hz.MultStartE = 1;
        cyc();
        hz.MultStartE = 0;
        repeat (7) cyc();
        hz.MultDoneE = 1;
        #1;
        check("t8_last_stall", hz8.stallF, 0);
        check("t8_last_busy", hz8.mult_busy, 1);
        cyc();
        hz.MultDoneE = 0;
        #1;
        check("t8_done_wins_busy", hz8.mult_busy, 0);
        check("t8_done_wins_fault", hz8.mult_fault, 0);

        // Ten stall cycles, a start while busy is ignored, release on done.
        cyc();
        hz.MultStartE = 1;
        cyc();
        stallCnt = 0;
        for (int k = 0; k < 10; k++) begin
            hz.MultStartE = (k == 4);
            #1 if (hz.stallF) stallCnt++;
            cyc();
        end
        hz.MultStartE = 0;
        hz.MultDoneE = 1;
        #1;
        check("mult_done_stall", hz.stallF, 0);
        check("mult_done_busy", hz.mult_busy, 1);
        cyc();
        hz.MultDoneE = 0;
        #1;
        check("mult_after_busy", hz.mult_busy, 0);
        check("mult_stall_cycles", stallCnt, 10);

        // Watchdog on the timeout-8 instance, then reset mid-BUSY.
        pulseRst();
        hz.MultStartE = 1;
        cyc();
        hz.MultStartE = 0;
        repeat (8) cyc();
        #1;
        check("t8_fault", hz8.mult_fault, 1);
        check("t8_fault_busy", hz8.mult_busy, 0);
        check("t8_fault_stall", hz8.stallF, 0);
        check("t64_still_busy", hz.stallF, 1);
        repeat (3) cyc();
        check("t8_fault_sticky", hz8.mult_fault, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", hz.mult_busy, 0);
        check("rst_async_stall", hz.stallF, 0);
        check("rst_async_fault", hz8.mult_fault, 0);
        cyc();
        rst = 1'b0;

`ifdef HAZARD_PERF_EN
        pulseRst();
        hz.WBSrcE = WB_MEM; hz.WriteRegE = 5; hz.RtD = 5;
        repeat (3) cyc();
        clearIn();
        hz.MultStartE = 1;
        cyc();
        hz.MultStartE = 0;
        repeat (2) cyc();
        hz.MultDoneE = 1;
        cyc();
        hz.MultDoneE = 0;
        cyc();
        check("perf_lw", lwCnt, 3);
        check("perf_mult", mCnt, 2);
        check("perf_br", brCnt, 0);
        check("perf8_lw", lwCnt8, 3);
        check("perf8_mult", mCnt8, 2);
        check("perf8_br", brCnt8, 0);
`endif

        repeat (2) cyc();
        running = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core; sits beside the datapath, consuming its per-stage register/control observations and producing stall, flush and forwarding selects back into it. Combinational forwarding/load-use/branch detection plus a sequential multiplier-occupancy FSM with watchdog. One instance per core, clocked with the datapath.

Parameters:
MULT_TIMEOUT, 64, max cycles in BUSY before watchdog fault (>=2)
CNT_W, 7, width of busy-cycle counter (must hold MULT_TIMEOUT)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
branchD  in  2  branch type in D; 2'b00 = no branch
RsD, RtD  in  5  source regs in D
RsE, RtE  in  5  source regs in E
WriteRegE  in  5  dest reg in E
RegWriteE  in  1  E writes regfile
WBSrcE  in  3  E writeback source
MultStartE  in  1  multiplier start pulse from E
MultDoneE  in  1  multiplier done pulse from E
WriteRegM  in  5  dest reg in M
RegWriteM  in  1  M writes regfile
WBSrcM  in  3  M writeback source
WriteRegW  in  5  dest reg in W
RegWriteW  in  1  W writes regfile
stallF, stallD  out  1  hold PC / IF-ID register
flushE  out  1  bubble ID-EX register
forwardAD, forwardBD  out  1  D-stage branch comparator forward from M
forwardAE, forwardBE  out  2  E operand select: 00 regfile, 10 from M, 01 from W
mult_busy  out  1  FSM in BUSY
mult_fault  out  1  sticky watchdog flag

Behaviour:
- Clock clk, reset rst: asynchronous, active-high. While rst=1 every output is 0, FSM=IDLE, counter=0, mult_fault=0.
- Register 0 never matches for any forward/stall compare.
- forwardAE: 10 if RegWriteM && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW==RsE; else 00. M wins when M and W both match. forwardBE identical on RtE.
- forwardAD = RegWriteM && WriteRegM==RsD; forwardBD likewise on RtD.
- lwstall = WBSrcE==WB_MEM && (WriteRegE==RsD || WriteRegE==RtD).
- brstall = branchD!=0 && ((RegWriteE && WriteRegE in {RsD,RtD}) || (WBSrcM==WB_MEM && WriteRegM in {RsD,RtD})).
- mstall = mult_busy && !MultDoneE (release in the cycle done arrives).
- stallF = stallD = flushE = lwstall | brstall | mstall. All combinational, zero latency.
- FSM IDLE/BUSY:
  - IDLE: MultStartE -> BUSY, counter cleared. MultDoneE in IDLE ignored.
  - BUSY: counter +1 per cycle. MultDoneE -> IDLE next edge. Counter reaching MULT_TIMEOUT-1 without done -> IDLE and mult_fault set.
  - MultStartE while BUSY ignored.
  - MultDoneE and timeout in the same cycle: done wins, no fault.
- mult_fault is sticky until rst.
- Reset asserted mid-BUSY: immediate IDLE, stalls drop asynchronously.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds output ports lw_stall_cnt, br_stall_cnt, mult_stall_cnt (32 bits each). Each counts cycles its stall term is 1, saturating at 2^32-1, reset to 0.
- Cycles with several terms active increment every active counter.
- Undefined: ports and counters absent; no other change.

Decomposition:
- Package hazard_pkg: WBSrc encoding (WB_ALU=3'd0, WB_MEM=3'd1, WB_PC8=3'd2, WB_HI=3'd3, WB_LO=3'd4), forward-select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), FSM state typedef.
- One sub-module: mult_tracker, holding the FSM, watchdog counter and sticky fault.
- Forwarding and stall compare logic stays in hazard_ctrl.

Test Plan:
- RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8, RtE=9 -> forwardAE=10, forwardBE=00. Drop RegWriteM -> forwardAE=01.
- WBSrcE=WB_MEM, WriteRegE=5, RtD=5 -> stallF=stallD=flushE=1. WriteRegE=0 with RsD=0 -> no stall.
- branchD=01, RegWriteE=1, WriteRegE=3, RsD=3 -> stall 1 cycle. Next cycle WriteRegM=3, RegWriteM=1, WBSrcM=WB_ALU -> no stall, forwardAD=1.
- MultStartE pulse, MultDoneE 10 cycles later -> mult_busy and stalls high 10 cycles, stalls 0 in the done cycle, mult_busy 0 the next.
- MULT_TIMEOUT=8, MultStartE, no done -> mult_fault=1 after 8 cycles, stalls 0, fault held until rst. rst pulse mid-BUSY -> all outputs 0 immediately.
- HAZARD_PERF_EN defined: 3 load-use stall cycles and 2 multiplier stall cycles -> lw_stall_cnt=3, mult_stall_cnt=2, br_stall_cnt=0.
